// File: rtl/jc_pkg.sv
// Shared definitions for Johnson-code (4-bit twisted ring) receive logic:
// widths, lock FSM states, the illegal-code set and the code-to-index decode.
package jc_pkg;

    localparam int JC_W = 4;
    localparam int PH_W = 3;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } jc_state_e;

    // Bit n set means code n is not a valid Johnson code (0010,0100,0101,0110,1001,1010,1011,1101).
    localparam logic [15:0] JC_ILLEGAL_MASK = 16'h2E74;

    function automatic logic [PH_W:0] jc2idx(input logic [JC_W-1:0] code);
        logic [PH_W-1:0] idx;
        case (code)
            4'b0000: idx = 3'd0;
            4'b1000: idx = 3'd1;
            4'b1100: idx = 3'd2;
            4'b1110: idx = 3'd3;
            4'b1111: idx = 3'd4;
            4'b0111: idx = 3'd5;
            4'b0011: idx = 3'd6;
            4'b0001: idx = 3'd7;
            default: idx = 3'd0;
        endcase
        return {~JC_ILLEGAL_MASK[code], idx};
    endfunction

endpackage

// File: rtl/jc_code_lut.sv
// Combinational Johnson-code decoder; reusable by any checker of the same code family.
module jc_code_lut
    import jc_pkg::*;
(
    input  logic [JC_W-1:0] code,
    output logic            legal,
    output logic [PH_W-1:0] idx
);

    assign {legal, idx} = jc2idx(code);

endmodule

// File: rtl/jc_decoder.sv
// Johnson-code stream decoder with phase output, illegal/sequence flags,
// a HUNT/CHECK/LOCKED lock FSM and a saturating mismatch counter.
module jc_decoder
    import jc_pkg::*;
#(
    parameter int LOCK_CNT  = 4,
    parameter int ERR_LIMIT = 2,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jc_vld,
    input  logic [JC_W-1:0]  jc_code,
    input  logic             err_clr,
    output logic [PH_W-1:0]  phase,
    output logic             phase_vld,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
    localparam logic [3:0]       LIMIT_C = 4'(ERR_LIMIT);
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    jc_state_e        state_r, state_nxt_s;
    logic [PH_W-1:0]  expected_r, expected_nxt_s;
    logic [3:0]       good_r, good_nxt_s;
    logic [3:0]       bad_r, bad_nxt_s;
    logic [PH_W-1:0]  phase_nxt_s;
    logic             phase_vld_nxt_s, illegal_nxt_s, seq_err_nxt_s;
    logic [ERR_W-1:0] err_nxt_s, err_inc_s;
    logic             legal_s, mismatch_s;
    logic [PH_W-1:0]  idx_s;

    jc_code_lut u_lut (
        .code  (jc_code),
        .legal (legal_s),
        .idx   (idx_s)
    );

    assign mismatch_s = ~legal_s | (idx_s != expected_r);
    assign err_inc_s  = (err_cnt == {ERR_W{1'b1}}) ? err_cnt : err_cnt + ERR_ONE;

    // Next-state, counters and output pulses for the current sample.
    always_comb begin
        state_nxt_s     = state_r;
        expected_nxt_s  = expected_r;
        good_nxt_s      = good_r;
        bad_nxt_s       = bad_r;
        phase_nxt_s     = phase;
        phase_vld_nxt_s = 1'b0;
        illegal_nxt_s   = 1'b0;
        seq_err_nxt_s   = 1'b0;
        err_nxt_s       = err_clr ? {ERR_W{1'b0}} : err_cnt;
        if (jc_vld) begin
            phase_vld_nxt_s = legal_s;
            illegal_nxt_s   = ~legal_s;
            phase_nxt_s     = legal_s ? idx_s : phase;
            case (state_r)
                HUNT: begin
                    if (legal_s) begin
                        expected_nxt_s = idx_s + 3'd1;
                        good_nxt_s     = 4'd1;
                        state_nxt_s    = CHECK;
                    end else begin
                        state_nxt_s    = HUNT;
                    end
                end
                CHECK: begin
                    if (!mismatch_s) begin
                        good_nxt_s     = good_r + 4'd1;
                        expected_nxt_s = idx_s + 3'd1;
                        state_nxt_s    = (good_r + 4'd1 == LOCK_C) ? LOCKED : CHECK;
                    end else if (legal_s) begin
                        seq_err_nxt_s  = 1'b1;
                        good_nxt_s     = 4'd1;
                        expected_nxt_s = idx_s + 3'd1;
                    end else begin
                        seq_err_nxt_s  = 1'b1;
                        state_nxt_s    = HUNT;
                    end
                end
                LOCKED: begin
                    if (!mismatch_s) begin
                        bad_nxt_s      = 4'd0;
                        expected_nxt_s = idx_s + 3'd1;
                    end else begin
                        // Flywheel: keep counting rather than resync to a suspect code.
                        seq_err_nxt_s  = 1'b1;
                        err_nxt_s      = err_clr ? ERR_ONE : err_inc_s;
                        expected_nxt_s = expected_r + 3'd1;
                        if (bad_r + 4'd1 == LIMIT_C) begin
                            bad_nxt_s   = 4'd0;
                            state_nxt_s = HUNT;
                        end else begin
                            bad_nxt_s   = bad_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_nxt_s = HUNT;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= HUNT;
            expected_r <= 3'd0;
            good_r     <= 4'd0;
            bad_r      <= 4'd0;
            phase      <= 3'd0;
            phase_vld  <= 1'b0;
            illegal    <= 1'b0;
            seq_err    <= 1'b0;
            locked     <= 1'b0;
            err_cnt    <= {ERR_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            expected_r <= expected_nxt_s;
            good_r     <= good_nxt_s;
            bad_r      <= bad_nxt_s;
            phase      <= phase_nxt_s;
            phase_vld  <= phase_vld_nxt_s;
            illegal    <= illegal_nxt_s;
            seq_err    <= seq_err_nxt_s;
            locked     <= (state_nxt_s == LOCKED);
            err_cnt    <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_jc_decoder.sv
// Scoreboard bench for jc_decoder: a behavioural model queues expected outputs
// per driven sample; they are popped and compared one cycle later.
module tb_jc_decoder;

    localparam int LOCK_CNT  = 4;
    localparam int ERR_LIMIT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       jc_vld = 1'b0;
    logic [3:0] jc_code = 4'b0000;
    logic       err_clr = 1'b0;
    logic [2:0] phase;
    logic       phase_vld, illegal, seq_err, locked;
    logic [7:0] err_cnt;

    jc_decoder #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .jc_vld(jc_vld), .jc_code(jc_code), .err_clr(err_clr),
        .phase(phase), .phase_vld(phase_vld), .illegal(illegal), .seq_err(seq_err),
        .locked(locked), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph; int pv; int il; int se; int lk; int ec;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] jc_tbl [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                               4'b1111, 4'b0111, 4'b0011, 4'b0001};

    int m_state, m_exp, m_good, m_bad, m_err, m_phase;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_exp = 0; m_good = 0; m_bad = 0; m_err = 0; m_phase = 0;
    endtask

    task automatic model_step(input logic vld, input logic [3:0] code, input logic clr);
        exp_t e;
        bit   legal;
        bit   mis;
        int   idx;
        legal = 0; idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (jc_tbl[i] == code) begin legal = 1; idx = i; end
        end
        mis = !legal || (idx != m_exp);
        e.pv = 0; e.il = 0; e.se = 0;
        if (clr) m_err = 0;
        if (vld) begin
            e.pv = legal; e.il = !legal;
            if (legal) m_phase = idx;
            if (m_state == 0) begin
                if (legal) begin m_exp = (idx + 1) % 8; m_good = 1; m_state = 1; end
            end else if (m_state == 1) begin
                if (!mis) begin
                    m_good++; m_exp = (idx + 1) % 8;
                    if (m_good == LOCK_CNT) m_state = 2;
                end else begin
                    e.se = 1;
                    if (legal) begin m_good = 1; m_exp = (idx + 1) % 8; end
                    else m_state = 0;
                end
            end else begin
                if (!mis) begin
                    m_bad = 0; m_exp = (idx + 1) % 8;
                end else begin
                    e.se = 1; m_bad++;
                    m_err = clr ? 1 : ((m_err < 255) ? m_err + 1 : 255);
                    m_exp = (m_exp + 1) % 8;
                    if (m_bad == ERR_LIMIT) begin m_state = 0; m_bad = 0; end
                end
            end
        end
        e.ph = m_phase; e.lk = (m_state == 2); e.ec = m_err;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 0, 1);
        end else begin
            e = sb.pop_front();
            check_eq("phase", phase, e.ph);
            check_eq("phase_vld", phase_vld, e.pv);
            check_eq("illegal", illegal, e.il);
            check_eq("seq_err", seq_err, e.se);
            check_eq("locked", locked, e.lk);
            check_eq("err_cnt", err_cnt, e.ec);
        end
    endtask

    task automatic send(input logic vld, input logic [3:0] code, input logic clr);
        @(negedge clk);
        jc_vld = vld; jc_code = code; err_clr = clr;
        model_step(vld, code, clr);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_phase"}, phase, 0);
        check_eq({tag, "_pv"}, phase_vld, 0);
        check_eq({tag, "_il"}, illegal, 0);
        check_eq({tag, "_se"}, seq_err, 0);
        check_eq({tag, "_lk"}, locked, 0);
        check_eq({tag, "_ec"}, err_cnt, 0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Lock-up sequence 0..5
        for (int i = 0; i < 6; i++) begin
            send(1'b1, jc_tbl[i], 1'b0);
            if (i == 2) check_eq("not_locked_3rd", locked, 0);
            if (i == 3) check_eq("lock_rise_4th", locked, 1);
        end

        // Legal out-of-sequence code while locked, then flywheel match
        send(1'b1, 4'b1100, 1'b0);
        check_eq("flywheel_se", seq_err, 1);
        check_eq("flywheel_ec", err_cnt, 1);
        check_eq("flywheel_lk", locked, 1);
        send(1'b1, 4'b0001, 1'b0);
        check_eq("flywheel_match_se", seq_err, 0);

        // Two illegal codes drop lock
        send(1'b1, 4'b0101, 1'b0);
        check_eq("ill1_lk", locked, 1);
        send(1'b1, 4'b1010, 1'b0);
        check_eq("ill2_il", illegal, 1);
        check_eq("ill2_lk", locked, 0);
        check_eq("ill2_ec", err_cnt, 3);

        // Lock progress across a jc_vld gap
        send(1'b1, 4'b1000, 1'b0);
        send(1'b1, 4'b1100, 1'b0);
        send(1'b1, 4'b1110, 1'b0);
        send(1'b0, 4'b0101, 1'b0);
        check_eq("gap_pv", phase_vld, 0);
        send(1'b1, 4'b1111, 1'b0);
        check_eq("gap_se", seq_err, 0);
        check_eq("gap_lock", locked, 1);

        // Saturate err_cnt with alternating mismatch/match
        for (int i = 0; i < 256; i++) begin
            send(1'b1, jc_tbl[(m_exp + 3) % 8], 1'b0);
            send(1'b1, jc_tbl[m_exp], 1'b0);
        end
        check_eq("err_sat", err_cnt, 255);
        send(1'b1, jc_tbl[(m_exp + 3) % 8], 1'b0);
        check_eq("err_sat_hold", err_cnt, 255);
        send(1'b1, jc_tbl[m_exp], 1'b0);
        send(1'b1, jc_tbl[(m_exp + 2) % 8], 1'b1);
        check_eq("err_clr_mis", err_cnt, 1);
        send(1'b1, jc_tbl[m_exp], 1'b0);
        send(1'b0, 4'b0000, 1'b1);
        check_eq("err_clr_only", err_cnt, 0);

        // Build err_cnt=3 while staying locked, then reset mid-stream
        for (int i = 0; i < 3; i++) begin
            send(1'b1, jc_tbl[(m_exp + 5) % 8], 1'b0);
            send(1'b1, jc_tbl[m_exp], 1'b0);
        end
        check_eq("pre_rst_lk", locked, 1);
        check_eq("pre_rst_ec", err_cnt, 3);
        @(negedge clk);
        rst_n = 1'b0; jc_vld = 1'b0; err_clr = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b1, 4'b0011, 1'b0);
        send(1'b1, 4'b0001, 1'b0);
        check_eq("post_rst_ph", phase, 7);
        check_eq("post_rst_lk", locked, 0);
        send(1'b1, 4'b1000, 1'b0);
        check_eq("post_rst_check_se", seq_err, 1);

        @(negedge clk);
        jc_vld = 1'b0;
        check_eq("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/jc_decoder.md
# jc_decoder

Receive-side companion to the 4-bit Johnson (twisted-ring) counter used in the width-conversion path. It samples a 4-bit Johnson code stream and decodes each code to a 3-bit phase index. It flags illegal codes and out-of-sequence steps, and runs a lock state machine so downstream logic only trusts the phase once the stream is stable. It also keeps a saturating error count for debug.

## Interface
Parameters:
- LOCK_CNT, 4: consecutive in-sequence legal codes required to enter LOCKED (range 2..15).
- ERR_LIMIT, 2: consecutive mismatches in LOCKED that drop lock (range 1..15).
- ERR_W, 8: width of err_cnt.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset; clk and rst_n are the only clock and reset.
- jc_vld, input, 1: jc_code is sampled this cycle.
- jc_code, input, 4: Johnson code from the counter.
- err_clr, input, 1: synchronous clear of err_cnt.
- phase, output, 3: decoded index of the last legal sample.
- phase_vld, output, 1: one-cycle pulse per sampled legal code.
- illegal, output, 1: one-cycle pulse per sampled illegal code.
- seq_err, output, 1: one-cycle pulse per sample that does not equal the expected phase while in CHECK or LOCKED.
- locked, output, 1: FSM is in LOCKED.
- err_cnt, output, ERR_W: saturating count of mismatches taken while LOCKED.

## Operation
- Legal map (code to idx): 0000 to 0, 1000 to 1, 1100 to 2, 1110 to 3, 1111 to 4, 0111 to 5, 0011 to 6, 0001 to 7. The other 8 codes are illegal.
- jc_vld=0: no state, counter or expected-phase change; all pulse outputs are 0.
- A mismatch is a sample that is illegal, or legal with idx != expected.
- expected is a 3-bit register and wraps 7 to 0.

FSM states are HUNT, CHECK and LOCKED. Reset state is HUNT.
- HUNT, legal sample: expected <= idx+1, good <= 1, go to CHECK.
- HUNT, illegal sample: stay in HUNT. No seq_err in HUNT.
- CHECK, match: good++, expected <= idx+1. When good+1 == LOCK_CNT, go to LOCKED.
- CHECK, legal mismatch: seq_err, restart with good <= 1, expected <= idx+1, stay in CHECK.
- CHECK, illegal sample: seq_err, go to HUNT.
- LOCKED, match: bad <= 0, expected <= idx+1.
- LOCKED, mismatch: seq_err, bad++, err_cnt++ (saturating), and expected <= expected+1 (flywheel, do not resync to the bad code). When bad+1 == ERR_LIMIT, go to HUNT and clear bad.
- err_cnt saturates at all ones. If err_clr and a LOCKED mismatch occur in the same cycle, err_cnt <= 1. err_clr alone sets err_cnt <= 0.
- phase updates only on legal samples and holds otherwise.

## Timing
- Everything is registered: a sample at rising edge N is reflected in outputs after edge N. Latency is 1 cycle.
- Reset values: phase=0, phase_vld=0, illegal=0, seq_err=0, locked=0, err_cnt=0, state=HUNT, expected=0, good=0, bad=0.
- locked asserts in the cycle after the LOCK_CNT-th in-sequence sample, on the same edge as that sample's phase_vld.
- Reset asserted mid-stream clears all state immediately. The first sample after release is treated as if in HUNT.
- A continuous jc_vld=1 stream at full clock rate is supported. There is no backpressure.

## Structure
- Package jc_pkg holds:
  - JC_W=4 and PH_W=3.
  - The state enum {HUNT, CHECK, LOCKED}.
  - The illegal-code constant set.
  - Function jc2idx(code) returning {legal, idx}.
- Sub-module jc_code_lut: purely combinational wrapper of jc2idx. It is shared with any future Johnson-code checkers.
- The top level holds the FSM, the good/bad counters (4 bits), expected, and the output registers.

## Test plan
- Reset, then drive 0000, 1000, 1100, 1110, 1111, 0111 with jc_vld=1 and LOCK_CNT=4. Phase must be 0,1,2,3,4,5 and phase_vld must pulse every cycle. locked must rise after the 4th sample (1110) and stay high.
- While locked, at expected idx 6 inject legal 1100 (idx 2). seq_err=1, err_cnt=1, locked stays 1. Then 0001 (idx 7) matches the flywheel and clears bad.
- While locked, inject 0101 then 1010 (ERR_LIMIT=2). illegal and seq_err pulse twice, err_cnt rises by 2, and locked falls after the second sample.
- Toggle jc_vld 1,0,1 mid-sequence: 1110, (gap), 1111. There must be no seq_err, and the lock progress counter must advance across the gap.
- Force err_cnt to 255 with repeated LOCKED mismatches. It must hold at 255. Assert err_clr together with a mismatch: err_cnt must become 1.
- Assert rst_n=0 while locked with err_cnt=3. All outputs must go to 0 immediately. After release, 0011 followed by 0001 gives phase 6,7, locked=0, state CHECK.
